// File: rtl/rf1_burst_ctrl.sv
// Burst initiator for a single-port register file with a 1-cycle registered read.
// Write beats go straight to the RAM; read beats return through a 2-entry FIFO.
module rf1_burst_ctrl #(
  parameter int M     = 128,
  parameter int N     = 8,
  parameter int WIDTH = 7,
  parameter int LENW  = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             CmdValid,
  output logic             CmdReady,
  input  logic             CmdWr,
  input  logic [WIDTH-1:0] CmdAddr,
  input  logic [LENW-1:0]  CmdLen,
  input  logic             WdValid,
  output logic             WdReady,
  input  logic [N-1:0]     WdData,
  output logic             RdValid,
  input  logic             RdReady,
  output logic [N-1:0]     RdData,
  output logic             RdLast,
  output logic             En,
  output logic             Wr,
  output logic [WIDTH-1:0] Addr,
  output logic [N-1:0]     WrData,
  input  logic [N-1:0]     Data
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] addr_q;
  logic [LENW-1:0]  rem_q;
  logic             inflight_q;
  logic             infl_last_q;
  logic [1:0]       occ_q;
  logic             wptr_q;
  logic             rptr_q;
  logic [N-1:0]     buf_data_q [2];
  logic [1:0]       buf_last_q;

  logic             wr_fire;
  logic             pop;
  logic [2:0]       level;
  logic             rd_issue;
  logic [WIDTH-1:0] addr_d;

  // A read may issue only if the entry it will produce is guaranteed a buffer slot.
  assign wr_fire  = (state_q == WRITE) && WdValid;
  assign pop      = (occ_q != 2'd0) && RdReady;
  assign level    = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign rd_issue = (state_q == READ) && (level < 3'd2);
  assign addr_d   = (addr_q == WIDTH'(M - 1)) ? '0 : addr_q + WIDTH'(1);

  assign CmdReady = (state_q == IDLE);
  assign WdReady  = (state_q == WRITE);
  assign En       = wr_fire || rd_issue;
  assign Wr       = wr_fire;
  assign Addr     = addr_q;
  assign WrData   = wr_fire ? WdData : '0;
  assign RdValid  = (occ_q != 2'd0);
  assign RdData   = buf_data_q[rptr_q];
  assign RdLast   = RdValid && buf_last_q[rptr_q];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      rem_q         <= '0;
      inflight_q    <= 1'b0;
      infl_last_q   <= 1'b0;
      occ_q         <= 2'd0;
      wptr_q        <= 1'b0;
      rptr_q        <= 1'b0;
      buf_data_q[0] <= '0;
      buf_data_q[1] <= '0;
      buf_last_q    <= 2'b00;
    end else begin
      case (state_q)
        IDLE: begin
          if (CmdValid) begin
            addr_q  <= CmdAddr;
            rem_q   <= CmdLen;
            state_q <= CmdWr ? WRITE : READ;
          end
        end
        WRITE: begin
          if (wr_fire) begin
            addr_q <= addr_d;
            if (rem_q == '0) state_q <= IDLE;
            else             rem_q   <= rem_q - LENW'(1);
          end
        end
        READ: begin
          if (rd_issue) begin
            addr_q <= addr_d;
            if (rem_q == '0) state_q <= DRAIN;
            else             rem_q   <= rem_q - LENW'(1);
          end
        end
        DRAIN: begin
          if (!inflight_q && occ_q == 2'd0) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      // RAM data for an issue made last cycle is valid now; capture it with its last tag.
      inflight_q  <= rd_issue;
      infl_last_q <= rd_issue && (rem_q == '0);
      if (inflight_q) begin
        buf_data_q[wptr_q] <= Data;
        buf_last_q[wptr_q] <= infl_last_q;
        wptr_q             <= ~wptr_q;
      end
      if (pop) rptr_q <= ~rptr_q;
      occ_q <= occ_q + 2'(inflight_q) - 2'(pop);
    end
  end

endmodule

// File: tb/tb_rf1_burst_ctrl.sv
// Bench for rf1_burst_ctrl: RAM environment, command-level reference model,
// directed table, hand sequences for stalls and reset, then randomized bursts.
module tb_rf1_burst_ctrl;
  localparam int M = 128, N = 8, WIDTH = 7, LENW = 4;

  logic             clk, reset_n;
  logic             CmdValid, CmdReady, CmdWr;
  logic [WIDTH-1:0] CmdAddr;
  logic [LENW-1:0]  CmdLen;
  logic             WdValid, WdReady;
  logic [N-1:0]     WdData;
  logic             RdValid, RdReady, RdLast;
  logic [N-1:0]     RdData;
  logic             En, Wr;
  logic [WIDTH-1:0] Addr;
  logic [N-1:0]     WrData, Data;

  rf1_burst_ctrl #(.M(M), .N(N), .WIDTH(WIDTH), .LENW(LENW)) dut (
    .clk(clk), .reset_n(reset_n),
    .CmdValid(CmdValid), .CmdReady(CmdReady), .CmdWr(CmdWr), .CmdAddr(CmdAddr), .CmdLen(CmdLen),
    .WdValid(WdValid), .WdReady(WdReady), .WdData(WdData),
    .RdValid(RdValid), .RdReady(RdReady), .RdData(RdData), .RdLast(RdLast),
    .En(En), .Wr(Wr), .Addr(Addr), .WrData(WrData), .Data(Data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic wr; logic [WIDTH-1:0] addr; logic [N-1:0] data; } acc_t;
  typedef struct { logic [N-1:0] data; logic last; } rd_t;
  typedef struct { logic wr; int addr; int len; logic [N-1:0] base; int exp_beats; int exp_last; } vec_t;

  acc_t         exp_acc[$];
  rd_t          exp_rd[$];
  logic [N-1:0] wbeats[$];
  logic [N-1:0] model_mem [M];
  logic [N-1:0] ram [M];

  int n_checks = 0, n_fail = 0;
  int cyc = 0, en_count = 0, first_en_cyc = -1, last_en_cyc = -1, first_rv_cyc = -1;
  logic [WIDTH-1:0] last_addr = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Register-file environment: synchronous write, registered read.
  initial begin
    for (int i = 0; i < M; i++) ram[i] = '0;
    Data = '0;
    forever begin
      @(posedge clk);
      if (En && !Wr) Data <= ram[int'(Addr)];
      if (En && Wr) ram[int'(Addr)] = WrData;
    end
  end

  // Monitor: every RAM access and every consumed read beat against the expectation queues.
  initial begin
    logic hold, hl;
    logic [N-1:0] hd;
    acc_t a;
    rd_t r;
    hold = 1'b0; hl = 1'b0; hd = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset_n) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          check("rd_hold_valid", 32'(RdValid), 32'd1);
          check("rd_hold_data", 32'(RdData), 32'(hd));
          check("rd_hold_last", 32'(RdLast), 32'(hl));
        end
        hold = RdValid && !RdReady; hd = RdData; hl = RdLast;
        if (RdValid && first_rv_cyc < 0) first_rv_cyc = cyc;
        if (En) begin
          en_count++;
          last_addr = Addr;
          if (first_en_cyc < 0) first_en_cyc = cyc;
          last_en_cyc = cyc;
          check("en_expected", 32'(exp_acc.size() != 0), 32'd1);
          if (exp_acc.size() != 0) begin
            a = exp_acc.pop_front();
            check("ram_wr", 32'(Wr), 32'(a.wr));
            check("ram_addr", 32'(Addr), 32'(a.addr));
            if (a.wr) check("ram_wrdata", 32'(WrData), 32'(a.data));
          end
        end
        if (RdValid && RdReady) begin
          check("rd_expected", 32'(exp_rd.size() != 0), 32'd1);
          if (exp_rd.size() != 0) begin
            r = exp_rd.pop_front();
            check("rd_data", 32'(RdData), 32'(r.data));
            check("rd_last", 32'(RdLast), 32'(r.last));
          end
        end
      end
    end
  end

  // Accept one command and derive all its expected accesses and beats from the model memory.
  task automatic send_cmd(input logic wr, input int addr, input int len, input logic [N-1:0] base);
    int a, guard;
    logic done;
    acc_t e;
    rd_t r;
    logic [N-1:0] d;
    CmdValid = 1'b1; CmdWr = wr; CmdAddr = WIDTH'(addr); CmdLen = LENW'(len);
    done = 1'b0; guard = 0;
    while (!done && guard < 200) begin
      @(negedge clk);
      if (CmdReady) begin
        done = 1'b1;
        a = addr;
        for (int i = 0; i <= len; i++) begin
          d = base + N'(i);
          e.wr = wr; e.addr = WIDTH'(a); e.data = wr ? d : '0;
          exp_acc.push_back(e);
          if (wr) begin
            model_mem[a] = d;
            wbeats.push_back(d);
          end else begin
            r.data = model_mem[a]; r.last = (i == len);
            exp_rd.push_back(r);
          end
          a = (a + 1) % M;
        end
      end
      @(posedge clk); #1;
      guard++;
    end
    CmdValid = 1'b0;
    check("cmd_accept", 32'(done), 32'd1);
  endtask

  task automatic drive_write(input logic gaps);
    int guard = 0;
    while (wbeats.size() != 0 && guard < 500) begin
      WdValid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      WdData  = wbeats[0];
      @(negedge clk);
      if (!WdValid) check("no_en_in_gap", 32'(En), 32'd0);
      if (WdValid && WdReady) void'(wbeats.pop_front());
      @(posedge clk); #1;
      guard++;
    end
    WdValid = 1'b0;
    check("wr_beats_done", 32'(wbeats.size()), 32'd0);
  endtask

  task automatic drain_read(input logic rnd);
    int guard = 0;
    while (exp_rd.size() != 0 && guard < 1000) begin
      RdReady = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      guard++;
    end
    RdReady = 1'b1;
    check("rd_beats_done", 32'(exp_rd.size()), 32'd0);
  endtask

  task automatic wait_idle();
    int guard = 0;
    logic done = 1'b0;
    while (!done && guard < 100) begin
      @(negedge clk);
      if (CmdReady) done = 1'b1;
      guard++;
      @(posedge clk); #1;
    end
    check("back_to_idle", 32'(done), 32'd1);
    check("acc_all_done", 32'(exp_acc.size()), 32'd0);
  endtask

  task automatic run_burst(input logic wr, input int addr, input int len, input logic [N-1:0] base, input logic rnd);
    send_cmd(wr, addr, len, base);
    if (wr) drive_write(rnd);
    else    drain_read(rnd);
    wait_idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t vt [6];

  initial begin
    vt[0] = '{1'b1, 'h10, 3, 8'hA0, 4, 'h13};
    vt[1] = '{1'b0, 'h10, 3, 8'h00, 4, 'h13};
    vt[2] = '{1'b1, M-2,  3, 8'h50, 4, 1};
    vt[3] = '{1'b0, M-2,  3, 8'h00, 4, 1};
    vt[4] = '{1'b1, 'h40, 0, 8'h77, 1, 'h40};
    vt[5] = '{1'b0, 'h40, 0, 8'h00, 1, 'h40};
    for (int i = 0; i < M; i++) model_mem[i] = '0;

    reset_n = 1'b0; CmdValid = 1'b0; CmdWr = 1'b0; CmdAddr = '0; CmdLen = '0;
    WdValid = 1'b1; WdData = 8'h5A; RdReady = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cmdready", 32'(CmdReady), 32'd1);
    check("rst_wdready", 32'(WdReady), 32'd0);
    check("rst_rdvalid", 32'(RdValid), 32'd0);
    check("rst_rdlast", 32'(RdLast), 32'd0);
    check("rst_en", 32'(En), 32'd0);
    check("rst_wr", 32'(Wr), 32'd0);
    check("rst_addr", 32'(Addr), 32'd0);
    check("rst_wrdata", 32'(WrData), 32'd0);
    check("rst_rddata", 32'(RdData), 32'd0);
    WdValid = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < 6; k++) begin
      en_count = 0; first_en_cyc = -1; last_en_cyc = -1; first_rv_cyc = -1;
      run_burst(vt[k].wr, vt[k].addr, vt[k].len, vt[k].base, 1'b0);
      check("beat_count", 32'(en_count), 32'(vt[k].exp_beats));
      check("last_addr", 32'(last_addr), 32'(vt[k].exp_last));
      if (!vt[k].wr) begin
        check("rd_first_latency", 32'(first_rv_cyc - first_en_cyc), 32'd2);
        check("rd_back_to_back", 32'(last_en_cyc - first_en_cyc), 32'(vt[k].exp_beats - 1));
      end
    end

    // Write with random WdValid gaps, then a read held off for 10 cycles.
    run_burst(1'b1, 'h20, 7, 8'h31, 1'b1);
    RdReady = 1'b0; en_count = 0;
    send_cmd(1'b0, 'h20, 7, 8'h00);
    repeat (10) @(posedge clk);
    #1;
    @(negedge clk);
    check("stall_en_count", 32'(en_count), 32'd2);
    check("stall_rdvalid", 32'(RdValid), 32'd1);
    check("stall_queue", 32'(exp_rd.size()), 32'd8);
    check("stall_beat0", 32'(RdData), 32'h31);
    check("stall_rdlast", 32'(RdLast), 32'd0);
    @(posedge clk); #1;
    drain_read(1'b0);
    wait_idle();
    check("stall_total_en", 32'(en_count), 32'd8);

    // Reset in the middle of a read burst with both buffer entries full.
    RdReady = 1'b0;
    send_cmd(1'b0, 'h30, 7, 8'h00);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("pre_rst_buffered", 32'(RdValid), 32'd1);
    @(posedge clk); #1;
    reset_n = 1'b0;
    exp_acc.delete(); exp_rd.delete();
    @(negedge clk);
    check("midrst_rdvalid", 32'(RdValid), 32'd0);
    check("midrst_en", 32'(En), 32'd0);
    check("midrst_cmdready", 32'(CmdReady), 32'd1);
    @(posedge clk); #1;
    reset_n = 1'b1; RdReady = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("postrst_rdvalid", 32'(RdValid), 32'd0);
      check("postrst_en", 32'(En), 32'd0);
      check("postrst_cmdready", 32'(CmdReady), 32'd1);
    end
    @(posedge clk); #1;
    run_burst(1'b1, 'h30, 2, 8'hC0, 1'b0);
    run_burst(1'b0, 'h30, 2, 8'h00, 1'b0);

    for (int k = 0; k < 40; k++) begin
      logic wr;
      int addr;
      wr = 1'($urandom_range(0, 1));
      addr = ($urandom_range(0, 3) == 0) ? (M - 1 - int'($urandom_range(0, 3))) : int'($urandom_range(0, M - 1));
      run_burst(wr, addr, int'($urandom_range(0, 15)), 8'($urandom), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
